// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  localparam logic [3:0] FRAME_PULSES_8N1 = 4'd11;
  localparam logic [3:0] FRAME_PULSES_8E1 = 4'd12;
  localparam logic       UART_IDLE        = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin winner; the last-served pointer lives in the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // Lone requester wins outright; on contention the source not served last wins.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-source UART transmit scheduler: arbitrates, latches a byte and sequences
// one serial frame against the external baud generator pulses.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter bit PARITY_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] gnt,
  output logic       bps_start,
  input  logic       clk_bps,
  output logic       tx,
  output logic       busy,
  output logic       src
);

  localparam logic [3:0] FRAME_PULSES = PARITY_EN ? FRAME_PULSES_8E1 : FRAME_PULSES_8N1;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] data_q, data_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic       bps_start_q, bps_start_d;
  logic       tx_q, tx_d;
  logic       src_q, src_d;

  logic       arb_valid;
  logic       arb_winner;
  logic [2:0] data_idx;
  logic       bit_val;

  rr_arb2 u_arb (
    .req   (req),
    .last  (last_q),
    .valid (arb_valid),
    .winner(arb_winner)
  );

  // Line level to drive for the pulse about to be counted; bit_cnt_q is pulses seen so far.
  always_comb begin
    data_idx = bit_cnt_q[2:0] - 3'd1;
    if (bit_cnt_q == 4'd0) begin
      bit_val = 1'b0;
    end else if (bit_cnt_q <= 4'd8) begin
      bit_val = data_q[data_idx];
    end else if (PARITY_EN && (bit_cnt_q == 4'd9)) begin
      bit_val = ^data_q;
    end else begin
      bit_val = UART_IDLE;
    end
  end

  // Next-state and registered-output logic for the IDLE/SEND/DONE sequence.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    data_d      = data_q;
    bit_cnt_d   = bit_cnt_q;
    gnt_d       = '0;
    bps_start_d = bps_start_q;
    tx_d        = tx_q;
    src_d       = src_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          last_d      = arb_winner;
          src_d       = arb_winner;
          data_d      = arb_winner ? data1 : data0;
          gnt_d       = arb_winner ? 2'b10 : 2'b01;
          bps_start_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (clk_bps) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          // The final pulse only closes the stop bit; the line is already high.
          if (bit_cnt_d == FRAME_PULSES) begin
            bps_start_d = 1'b0;
            state_d     = DONE;
          end else begin
            tx_d = bit_val;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset to an idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      data_q      <= '0;
      bit_cnt_q   <= '0;
      gnt_q       <= '0;
      bps_start_q <= 1'b0;
      tx_q        <= UART_IDLE;
      src_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      data_q      <= data_d;
      bit_cnt_q   <= bit_cnt_d;
      gnt_q       <= gnt_d;
      bps_start_q <= bps_start_d;
      tx_q        <= tx_d;
      src_q       <= src_d;
    end
  end

  assign gnt       = gnt_q;
  assign bps_start = bps_start_q;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign src       = src_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: one 8N1 and one 8E1 instance, each against a
// frame-level model and a bench baud generator.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic [1:0] req     [2];
  logic [7:0] data0   [2];
  logic [7:0] data1   [2];
  logic       clk_bps [2];
  logic [1:0] gnt_w   [2];
  logic       bps_w   [2];
  logic       tx_w    [2];
  logic       busy_w  [2];
  logic       src_w   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_tx_sched #(.PARITY_EN(g == 1)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req[g]),
      .data0    (data0[g]),
      .data1    (data1[g]),
      .gnt      (gnt_w[g]),
      .bps_start(bps_w[g]),
      .clk_bps  (clk_bps[g]),
      .tx       (tx_w[g]),
      .busy     (busy_w[g]),
      .src      (src_w[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model: phase 0 idle, 1 shifting out m_frame, 2 one-cycle gap.
  int         m_phase [2];
  logic       m_frame [2][11];
  int         m_len   [2];
  int         m_pos   [2];
  logic       m_ptr   [2];
  logic [1:0] m_gnt   [2];
  logic       m_bps   [2];
  logic       m_tx    [2];
  logic       m_busy  [2];
  logic       m_src   [2];

  // Bench-side baud generator and observation records.
  int   cyc = 0;
  int   bcnt [2];
  bit   inject [2];
  bit   pulse_prev [2];
  bit   bps_prev [2];
  int   pulse_cnt [2];
  int   fall_pulses [2];
  int   fall_cyc [2];
  int   gnt_cyc [2];
  logic rec_tx [2][16];
  int   n_tx [2];
  logic [1:0] rec_gnt [2][8];
  logic rec_src [2][8];
  int   n_gnt [2];
  bit   rand_mode = 1'b0;

  task automatic check(input string name, input int inst, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic void model_reset(input int i);
    m_phase[i] = 0;
    m_len[i]   = 0;
    m_pos[i]   = 0;
    m_ptr[i]   = 1'b1;
    m_gnt[i]   = 2'b00;
    m_bps[i]   = 1'b0;
    m_tx[i]    = 1'b1;
    m_busy[i]  = 1'b0;
    m_src[i]   = 1'b0;
  endfunction

  function automatic void model_edge(input int i);
    logic [7:0] b;
    int w;
    if (rst) begin
      model_reset(i);
      return;
    end
    m_gnt[i] = 2'b00;
    if (m_phase[i] == 0) begin
      if (req[i] != 2'b00) begin
        w = (req[i] == 2'b11) ? int'(!m_ptr[i]) : int'(req[i][1]);
        m_ptr[i] = w[0];
        m_src[i] = w[0];
        m_gnt[i] = 2'b01 << w;
        b = (w == 1) ? data1[i] : data0[i];
        m_frame[i][0] = 1'b0;
        for (int k = 0; k < 8; k++) m_frame[i][k+1] = b[k];
        m_len[i] = 9;
        if (i == 1) begin
          m_frame[i][9] = ^b;
          m_len[i] = 10;
        end
        m_frame[i][m_len[i]] = 1'b1;
        m_len[i]++;
        m_pos[i]   = 0;
        m_phase[i] = 1;
        m_bps[i]   = 1'b1;
        m_busy[i]  = 1'b1;
      end
    end else if (m_phase[i] == 1) begin
      if (clk_bps[i]) begin
        if (m_pos[i] < m_len[i]) begin
          m_tx[i] = m_frame[i][m_pos[i]];
          m_pos[i]++;
        end else begin
          m_phase[i] = 2;
          m_bps[i]   = 1'b0;
        end
      end
    end else begin
      m_phase[i] = 0;
      m_busy[i]  = 1'b0;
    end
  endfunction

  task automatic rand_drive(input int i);
    for (int s = 0; s < 2; s++) begin
      if (m_gnt[i][s]) begin
        if ($urandom_range(1, 0) == 1) begin
          if (s == 0) data0[i] = 8'($urandom); else data1[i] = 8'($urandom);
        end else begin
          req[i][s] = 1'b0;
        end
      end else if (req[i][s]) begin
        if ($urandom_range(63, 0) == 0) req[i][s] = 1'b0;
      end else if ($urandom_range(7, 0) == 0) begin
        req[i][s] = 1'b1;
        if (s == 0) data0[i] = 8'($urandom); else data1[i] = 8'($urandom);
      end else begin
        if (s == 0) data0[i] = 8'($urandom); else data1[i] = 8'($urandom);
      end
    end
    inject[i] = (m_phase[i] != 1) && ($urandom_range(15, 0) == 0);
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      pulse_prev[i] = clk_bps[i];
      model_edge(i);
    end
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      check("gnt", i, 8'(gnt_w[i]), 8'(m_gnt[i]));
      check("bps_start", i, 8'(bps_w[i]), 8'(m_bps[i]));
      check("tx", i, 8'(tx_w[i]), 8'(m_tx[i]));
      check("busy", i, 8'(busy_w[i]), 8'(m_busy[i]));
      check("src", i, 8'(src_w[i]), 8'(m_src[i]));
      if (bps_w[i] && !bps_prev[i]) pulse_cnt[i] = 0;
      if (pulse_prev[i]) pulse_cnt[i]++;
      if (pulse_prev[i] && bps_w[i] && n_tx[i] < 16) begin
        rec_tx[i][n_tx[i]] = tx_w[i];
        n_tx[i]++;
      end
      if (!bps_w[i] && bps_prev[i]) begin
        fall_pulses[i] = pulse_cnt[i];
        fall_cyc[i]    = cyc;
      end
      if (gnt_w[i] != 2'b00 && n_gnt[i] < 8) begin
        rec_gnt[i][n_gnt[i]] = gnt_w[i];
        rec_src[i][n_gnt[i]] = src_w[i];
        gnt_cyc[i] = cyc;
        n_gnt[i]++;
      end
      bps_prev[i] = bps_w[i];
      if (rand_mode) rand_drive(i);
      if (!bps_w[i]) bcnt[i] = 0; else bcnt[i]++;
      clk_bps[i] = (bps_w[i] && bcnt[i] >= 8 && ((bcnt[i] - 8) % 16) == 0) || inject[i];
    end
  endtask

  task automatic wait_idle();
    int budget = 1000;
    while ((m_phase[0] != 0 || m_phase[1] != 0) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) timeout("wait_idle");
  endtask

  task automatic clear_recs();
    for (int i = 0; i < 2; i++) begin
      n_tx[i]  = 0;
      n_gnt[i] = 0;
    end
  endtask

  initial begin
    logic [9:0]  exp_a5;
    logic [10:0] exp_07;
    logic [1:0]  exp_alt;
    int budget;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 2'b00; data0[i] = '0; data1[i] = '0; clk_bps[i] = 1'b0;
      inject[i] = 1'b0; bcnt[i] = 0; pulse_prev[i] = 1'b0; bps_prev[i] = 1'b0;
      pulse_cnt[i] = 0; fall_pulses[i] = 0; fall_cyc[i] = 0; gnt_cyc[i] = 0;
      model_reset(i);
    end
    clear_recs();

    // Reset values.
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      check("rst_gnt", i, 8'(gnt_w[i]), 8'h00);
      check("rst_bps", i, 8'(bps_w[i]), 8'h00);
      check("rst_tx", i, 8'(tx_w[i]), 8'h01);
      check("rst_busy", i, 8'(busy_w[i]), 8'h00);
      check("rst_src", i, 8'(src_w[i]), 8'h00);
    end
    rst = 1'b0;
    step();

    // Baud pulses while idle are ignored.
    for (int k = 0; k < 24; k++) begin
      inject[0] = (k % 3 == 0);
      inject[1] = (k % 3 == 1);
      step();
    end
    inject[0] = 1'b0;
    inject[1] = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 2; i++) begin
      check("idle_pulse_gnts", i, 8'(n_gnt[i]), 8'd0);
      check("idle_pulse_tx", i, 8'(tx_w[i]), 8'h01);
    end

    // Single byte A5 on the 8N1 instance; 07 from source 1 on the 8E1 instance.
    clear_recs();
    req[0] = 2'b01; data0[0] = 8'hA5;
    req[1] = 2'b10; data1[1] = 8'h07;
    step();
    req[0] = 2'b00;
    req[1] = 2'b00;
    check("single_gnt", 0, 8'(gnt_w[0]), 8'h01);
    check("parity_gnt", 1, 8'(gnt_w[1]), 8'h02);
    step();
    check("gnt_pulse_width", 0, 8'(gnt_w[0]), 8'h00);
    wait_idle();
    exp_a5 = 10'b1101001010;
    exp_07 = 11'b11000001110;
    check("a5_bits", 0, 8'(n_tx[0]), 8'd10);
    for (int k = 0; k < 10; k++) check("a5_tx", k, 8'(rec_tx[0][k]), 8'(exp_a5[k]));
    check("a5_pulses", 0, 8'(fall_pulses[0]), 8'd11);
    check("p07_bits", 1, 8'(n_tx[1]), 8'd11);
    for (int k = 0; k < 11; k++) check("p07_tx", k, 8'(rec_tx[1][k]), 8'(exp_07[k]));
    check("p07_pulses", 1, 8'(fall_pulses[1]), 8'd12);
    check("single_gnt_count", 0, 8'(n_gnt[0]), 8'd1);

    // Reset in the middle of a 3C frame.
    clear_recs();
    req[0] = 2'b01; data0[0] = 8'h3C;
    step();
    req[0] = 2'b00;
    budget = 400;
    while (pulse_cnt[0] < 5 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) timeout("wait_pulse5");
    check("pre_rst_bps", 0, 8'(bps_w[0]), 8'h01);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midrst_tx", i, 8'(tx_w[i]), 8'h01);
      check("midrst_bps", i, 8'(bps_w[i]), 8'h00);
      check("midrst_busy", i, 8'(busy_w[i]), 8'h00);
      check("midrst_gnt", i, 8'(gnt_w[i]), 8'h00);
      model_reset(i);
    end
    step();
    rst = 1'b0;
    step();

    // Continuous contention: grants must alternate starting from source 0.
    clear_recs();
    for (int i = 0; i < 2; i++) begin
      req[i] = 2'b11; data0[i] = 8'h5A; data1[i] = 8'hC3;
    end
    budget = 2000;
    while ((n_gnt[0] < 4 || n_gnt[1] < 4) && budget > 0) begin
      step();
      for (int i = 0; i < 2; i++) if (n_gnt[i] >= 4) req[i] = 2'b00;
      budget--;
    end
    if (budget == 0) timeout("contention");
    req[0] = 2'b00;
    req[1] = 2'b00;
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        exp_alt = (k % 2 == 0) ? 2'b01 : 2'b10;
        check("rr_gnt", i, 8'(rec_gnt[i][k]), 8'(exp_alt));
        check("rr_src", i, 8'(rec_src[i][k]), 8'(k % 2));
      end
    end

    // Back-to-back on source 0: next grant exactly two cycles after bps_start falls.
    clear_recs();
    req[0] = 2'b01; data0[0] = 8'($urandom);
    budget = 1000;
    while (n_gnt[0] < 2 && budget > 0) begin
      step();
      if (gnt_w[0] != 2'b00) data0[0] = 8'($urandom);
      budget--;
    end
    if (budget == 0) timeout("back_to_back");
    req[0] = 2'b00;
    check("b2b_gap", 0, 8'(gnt_cyc[0] - fall_cyc[0]), 8'd2);
    wait_idle();

    // Randomized traffic, idle pulse injection included.
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 2'b00;
      inject[i] = 1'b0;
    end
    step();
    wait_idle();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
